nn_upsample2d: RTL

// - 16-channel nearest-neighbour 2-D upsampler: inverse direction of the avg-pooling stage.
// - Each input pixel is replicated SCALE x SCALE in the output frame.
// - Sits on the decoder side of the feature-map pipeline.
// - Streams the same sof/valid/d[15:0] pixel interface that the pooling stage consumes.
// - A one-row line buffer plus a row-replay FSM regenerate the enlarged frame.

---
 rtl/nn_upsample2d_if.sv | 27 ++
 rtl/nn_upsample2d.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/nn_upsample2d_if.sv
// Pixel-stream bundle for the nearest-neighbour upsampler.
// Carries both the input side (sof / input_valid / i_ready / d_in) and the
// output side (o_sof / output_valid / d_out) of the block.
//   master : the environment (drives input pixels, observes outputs)
//   slave  : the upsampler itself
interface nn_upsample2d_if #(
  parameter int DATA_W = 32,
  parameter int CH     = 16
);
  logic                         sof;
  logic                         input_valid;
  logic                         i_ready;
  logic [CH-1:0][DATA_W-1:0]    d_in;
  logic                         o_sof;
  logic                         output_valid;
  logic [CH-1:0][DATA_W-1:0]    d_out;

  modport master (
    output sof, input_valid, d_in,
    input  i_ready, o_sof, output_valid, d_out
  );

  modport slave (
    input  sof, input_valid, d_in,
    output i_ready, o_sof, output_valid, d_out
  );
endinterface

// File: rtl/nn_upsample2d.sv
// nn_upsample2d: CH-lane nearest-neighbour 2-D upsampler.
// Each input row (IN_W pixels) is captured into a one-row line buffer, then
// replayed SCALE times, with every pixel repeated SCALE times, giving a
// frame enlarged by SCALE in both directions. Lanes share one FSM and are
// copied bit-exactly.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous reset, active-high
//   bus  - slave side of nn_upsample2d_if
//          in : sof, input_valid, d_in     out: i_ready (0 while emitting)
//          out: o_sof, output_valid, d_out (registered)
module nn_upsample2d #(
  parameter int DATA_W = 32,
  parameter int CH     = 16,
  parameter int IN_W   = 8,
  parameter int IN_H   = 8,
  parameter int SCALE  = 2
) (
  input  logic            clk,
  input  logic            rst,
  nn_upsample2d_if.slave  bus
);

  localparam int COL_W = $clog2(IN_W + 1);
  localparam int ROW_W = $clog2(IN_H + 1);
  localparam int SC_W  = $clog2(SCALE + 1);
  localparam int IDX_W = (IN_W > 1) ? $clog2(IN_W) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_H - 1);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SCALE - 1);

  typedef logic [CH-1:0][DATA_W-1:0] pix_t;
  typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

  state_t           state, state_nx;
  logic [COL_W-1:0] col, col_nx;
  logic [ROW_W-1:0] row, row_nx;
  logic [SC_W-1:0]  sub, sub_nx;
  logic [SC_W-1:0]  rep, rep_nx;
  logic             wr_en;
  logic [COL_W-1:0] wr_idx;
  logic             accept;
  logic             first_px;

  pix_t             line_buf [IN_W];
  pix_t             d_out_q;
  logic             o_sof_q;
  logic             out_valid_q;

  assign bus.i_ready      = (state != EMIT);
  assign bus.d_out        = d_out_q;
  assign bus.o_sof        = o_sof_q;
  assign bus.output_valid = out_valid_q;

  assign accept   = bus.input_valid && (state != EMIT);
  assign first_px = (state == EMIT) && (row == '0) && (rep == '0) &&
                    (col == '0) && (sub == '0);

  always_comb begin
    state_nx = state;
    col_nx   = col;
    row_nx   = row;
    sub_nx   = sub;
    rep_nx   = rep;
    wr_en    = 1'b0;
    wr_idx   = '0;
    case (state)
      IDLE: begin
        if (accept && bus.sof) begin
          wr_en  = 1'b1;
          wr_idx = '0;
          row_nx = '0;
          // A one-pixel row is complete on its sof beat.
          if (COL_LAST == '0) begin
            col_nx   = '0;
            state_nx = EMIT;
          end else begin
            col_nx   = COL_W'(1);
            state_nx = LOAD;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          wr_en  = 1'b1;
          // sof mid-load restarts the frame at column 0, row 0.
          wr_idx = bus.sof ? '0 : col;
          if (bus.sof) row_nx = '0;
          if (wr_idx == COL_LAST) begin
            col_nx   = '0;
            state_nx = EMIT;
          end else begin
            col_nx = wr_idx + COL_W'(1);
          end
        end
      end
      EMIT: begin
        // Nested counters: sub (pixel repeat) -> col -> rep (row repeat).
        if (sub == SC_LAST) begin
          sub_nx = '0;
          if (col == COL_LAST) begin
            col_nx = '0;
            if (rep == SC_LAST) begin
              rep_nx = '0;
              if (row == ROW_LAST) begin
                row_nx   = '0;
                state_nx = IDLE;
              end else begin
                row_nx   = row + ROW_W'(1);
                state_nx = LOAD;
              end
            end else begin
              rep_nx = rep + SC_W'(1);
            end
          end else begin
            col_nx = col + COL_W'(1);
          end
        end else begin
          sub_nx = sub + SC_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      col         <= '0;
      row         <= '0;
      sub         <= '0;
      rep         <= '0;
      d_out_q     <= '0;
      o_sof_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_nx;
      col         <= col_nx;
      row         <= row_nx;
      sub         <= sub_nx;
      rep         <= rep_nx;
      out_valid_q <= (state == EMIT);
      o_sof_q     <= first_px;
      if (state == EMIT) d_out_q <= line_buf[IDX_W'(col)];
    end
  end

  // Line buffer holds no reset: contents are only read after a full row load.
  always_ff @(posedge clk) begin
    if (wr_en) line_buf[IDX_W'(wr_idx)] <= bus.d_in;
  end

endmodule
